// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths and the writeback request bundle for the
// register-file write-port arbiter.
package wb_port_arbiter_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              we;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_req_fifo.sv
// Holding FIFO for multi-cycle unit results awaiting the
// register-file write port; DEPTH must be a power of two.
module wb_req_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_req_t                  din,
  input  logic                     pop,
  output wb_req_t                  head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_req_t        mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs MDU FIFO.
// Optional starvation guard enabled by WB_STARVE_GUARD_EN.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we,
  input  logic [REG_W-1:0]  pipe_reg,
  input  logic [DATA_W-1:0] pipe_data,
  output logic              pipe_stall,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [REG_W-1:0]  mdu_reg,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              mdu_pending,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0] count;
  wb_req_t       head;
  wb_req_t       mdu_req;
  wb_req_t       sel;
  logic          pending;
  logic          push;
  logic          pop;
  logic          force_drain;
  logic          wr;

  assign pending     = count != '0;
  assign mdu_ready   = count != CW'(FIFO_DEPTH);
  assign mdu_pending = pending;
  assign push        = mdu_valid && mdu_ready;
  assign mdu_req     = '{we: 1'b1, rd: mdu_reg, data: mdu_data};

  wb_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (mdu_req),
    .pop   (pop),
    .head  (head),
    .count (count)
  );

`ifdef WB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve;

  assign force_drain = pending && (starve == SW'(STARVE_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve <= '0;
    end else if (!pending || pop) begin
      starve <= '0;
    end else if (pipe_we && starve != SW'(STARVE_LIMIT)) begin
      starve <= starve + SW'(1);
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg  = |STARVE_LIMIT;
  assign force_drain = 1'b0;
`endif

  assign pop        = pending && (!pipe_we || force_drain);
  assign pipe_stall = pipe_we && force_drain;

  always_comb begin
    sel = '{we: pipe_we, rd: pipe_reg, data: pipe_data};
    if (pop) sel = head;
  end

  // Writes to x0 are granted (and popped) but never reach the file.
  assign wr = sel.we && (sel.rd != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= wr;
      if (wr) begin
        rf_waddr <= sel.rd;
        rf_wdata <= sel.data;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: vector table, corner
// sequences and randomized traffic against a queue-based model.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_reg = '0;
  logic [31:0] pipe_data = '0;
  logic        pipe_stall;
  logic        mdu_valid = 1'b0;
  logic        mdu_ready;
  logic [4:0]  mdu_reg = '0;
  logic [31:0] mdu_data = '0;
  logic        mdu_pending;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pipe_we     (pipe_we),
    .pipe_reg    (pipe_reg),
    .pipe_data   (pipe_data),
    .pipe_stall  (pipe_stall),
    .mdu_valid   (mdu_valid),
    .mdu_ready   (mdu_ready),
    .mdu_reg     (mdu_reg),
    .mdu_data    (mdu_data),
    .mdu_pending (mdu_pending),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue of pending results and a wait count.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  int          starve;
  bit          m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          e_stall;
  bit          e_ready;
  bit          e_pend;

  task automatic model_reset();
    q.delete();
    starve = 0;
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  task automatic model_step();
    bit          fd;
    bit          granted;
    bit          popped;
    logic [4:0]  g_rd;
    logic [31:0] g_d;
    ent_t        h;
    ent_t        n;
    e_pend  = q.size() != 0;
    e_ready = q.size() < DEPTH;
    fd      = GUARD && e_pend && (starve == LIMIT);
    e_stall = pipe_we && fd;
    granted = 1'b0;
    popped  = 1'b0;
    g_rd    = '0;
    g_d     = '0;
    if (e_pend && (!pipe_we || fd)) begin
      h       = q.pop_front();
      popped  = 1'b1;
      granted = 1'b1;
      g_rd    = h.rd;
      g_d     = h.d;
    end else if (pipe_we) begin
      granted = 1'b1;
      g_rd    = pipe_reg;
      g_d     = pipe_data;
    end
    if (!e_pend || popped) starve = 0;
    else if (granted && starve < LIMIT) starve++;
    if (mdu_valid && e_ready) begin
      n.rd = mdu_reg;
      n.d  = mdu_data;
      q.push_back(n);
    end
    m_we = granted && (g_rd != 0);
    if (m_we) begin
      m_addr = g_rd;
      m_data = g_d;
    end
  endtask

  task automatic drive(input bit pw, input logic [4:0] pr,
                       input logic [31:0] pd, input bit mv,
                       input logic [4:0] mr, input logic [31:0] md);
    pipe_we   = pw;
    pipe_reg  = pr;
    pipe_data = pd;
    mdu_valid = mv;
    mdu_reg   = mr;
    mdu_data  = md;
  endtask

  task automatic tick_model(input string tag);
    #1;
    model_step();
    chk({tag, "_stall"}, pipe_stall, e_stall);
    chk({tag, "_ready"}, mdu_ready, e_ready);
    chk({tag, "_pend"}, mdu_pending, e_pend);
    @(posedge clk);
    #1;
    chk({tag, "_rf_we"}, rf_we, m_we);
    if (m_we) begin
      chk({tag, "_waddr"}, rf_waddr, m_addr);
      chk({tag, "_wdata"}, rf_wdata, m_data);
    end
  endtask

  typedef struct {
    bit          pw;
    logic [4:0]  pr;
    logic [31:0] pd;
    bit          mv;
    logic [4:0]  mr;
    logic [31:0] md;
    bit          stall;
    bit          ready;
    bit          pend;
    bit          we;
    logic [4:0]  addr;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [31:0] pd;
    bit          st;
    bit          last_stall;
    bit          pw;
    logic [4:0]  pr;
    logic [31:0] pdat;

    tbl[0]  = '{1, 8, 32'h12345678, 0, 0, 0,     0, 1, 0, 1, 8, 32'h12345678};
    tbl[1]  = '{0, 0, 0, 1, 3, 32'hA,            0, 1, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 1, 4, 32'hB,            0, 1, 1, 1, 3, 32'hA};
    tbl[3]  = '{0, 0, 0, 0, 0, 0,                0, 1, 1, 1, 4, 32'hB};
    tbl[4]  = '{0, 0, 0, 0, 0, 0,                0, 1, 0, 0, 0, 0};
    tbl[5]  = '{1, 5, 32'h55, 1, 6, 32'h66,      0, 1, 0, 1, 5, 32'h55};
    tbl[6]  = '{1, 7, 32'h77, 1, 9, 32'h99,      0, 1, 1, 1, 7, 32'h77};
    tbl[7]  = '{1, 10, 32'hAA, 1, 11, 32'hBB,    0, 0, 1, 1, 10, 32'hAA};
    tbl[8]  = '{0, 0, 0, 0, 0, 0,                0, 0, 1, 1, 6, 32'h66};
    tbl[9]  = '{0, 0, 0, 0, 0, 0,                0, 1, 1, 1, 9, 32'h99};
    tbl[10] = '{0, 0, 0, 0, 0, 0,                0, 1, 0, 0, 0, 0};
    tbl[11] = '{1, 0, 32'hDEAD, 1, 0, 32'h1,     0, 1, 0, 0, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 0, 0,                0, 1, 1, 0, 0, 0};
    tbl[13] = '{0, 0, 0, 0, 0, 0,                0, 1, 0, 0, 0, 0};

    #2;
    chk("reset_rf_we", rf_we, 0);
    chk("reset_waddr", rf_waddr, 0);
    chk("reset_wdata", rf_wdata, 0);
    chk("reset_pend", mdu_pending, 0);
    chk("reset_ready", mdu_ready, 1);
    chk("reset_stall", pipe_stall, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].pw, tbl[i].pr, tbl[i].pd,
            tbl[i].mv, tbl[i].mr, tbl[i].md);
      #1;
      model_step();
      chk($sformatf("vec%0d_stall", i), pipe_stall, tbl[i].stall);
      chk($sformatf("vec%0d_ready", i), mdu_ready, tbl[i].ready);
      chk($sformatf("vec%0d_pend", i), mdu_pending, tbl[i].pend);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_rf_we", i), rf_we, tbl[i].we);
      if (tbl[i].we) begin
        chk($sformatf("vec%0d_waddr", i), rf_waddr, tbl[i].addr);
        chk($sformatf("vec%0d_wdata", i), rf_wdata, tbl[i].data);
      end
    end

    // Continuous pipeline traffic with one MDU result waiting.
    pd = 32'd100;
    drive(1, 1, pd, 1, 12, 32'hC);
    tick_model("starve_c0");
    pd++;
    for (int c = 1; c <= 6; c++) begin
      drive(1, 1, pd, 0, 0, 0);
      #1;
      st = GUARD && (c == 5);
      chk($sformatf("starve_c%0d_stall", c), pipe_stall, st);
      chk($sformatf("starve_c%0d_pend", c), mdu_pending, 1);
      model_step();
      @(posedge clk);
      #1;
      chk($sformatf("starve_c%0d_rf_we", c), rf_we, 1);
      chk($sformatf("starve_c%0d_waddr", c), rf_waddr,
          st ? 32'd12 : 32'd1);
      chk($sformatf("starve_c%0d_wdata", c), rf_wdata,
          st ? 32'hC : pd);
      if (!st) pd++;
    end
    drive(0, 0, 0, 0, 0, 0);
    tick_model("starve_drain0");
    tick_model("starve_drain1");

    // Asynchronous reset while two results are queued.
    drive(1, 2, 32'h20, 1, 13, 32'hD1);
    tick_model("fill0");
    drive(1, 3, 32'h30, 1, 14, 32'hD2);
    tick_model("fill1");
    chk("fill_pend", mdu_pending, 1);
    chk("fill_ready", mdu_ready, 0);
    drive(0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_rf_we", rf_we, 0);
    chk("arst_waddr", rf_waddr, 0);
    chk("arst_wdata", rf_wdata, 0);
    chk("arst_pend", mdu_pending, 0);
    chk("arst_ready", mdu_ready, 1);
    chk("arst_stall", pipe_stall, 0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    tick_model("post_rst0");
    tick_model("post_rst1");

    // Randomized traffic; a stalled pipeline request is held.
    last_stall = 1'b0;
    pw   = 1'b0;
    pr   = '0;
    pdat = '0;
    for (int i = 0; i < 400; i++) begin
      if (!last_stall) begin
        pw   = $urandom_range(0, 99) < 65;
        pr   = ($urandom_range(0, 9) == 0) ? 5'd0
                                           : 5'($urandom_range(1, 31));
        pdat = $urandom;
      end
      drive(pw, pr, pdat, $urandom_range(0, 99) < 45,
            ($urandom_range(0, 9) == 0) ? 5'd0
                                        : 5'($urandom_range(1, 31)),
            $urandom);
      tick_model($sformatf("rnd%0d", i));
      last_stall = e_stall;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, meaning MDU holding-FIFO entries (power of two, min 2).
REQ-002 Parameter STARVE_LIMIT, default 4, meaning consecutive pipeline wins tolerated while FIFO non-empty.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 pipe_we  input  1  writeback stage requests a register-file write this cycle.
REQ-006 pipe_reg  input  5  writeback destination register.
REQ-007 pipe_data  input  32  writeback data, already extended and selected.
REQ-008 pipe_stall  output  1  combinational, pipeline must hold the writeback stage this cycle.
REQ-009 mdu_valid  input  1  multi-cycle unit offers a result.
REQ-010 mdu_ready  output  1  FIFO can accept a result.
REQ-011 mdu_reg  input  5  MDU destination register.
REQ-012 mdu_data  input  32  MDU result.
REQ-013 mdu_pending  output  1  FIFO non-empty, used by the hazard unit.
REQ-014 rf_we  output  1  registered register-file write enable.
REQ-015 rf_waddr  output  5  registered write address.
REQ-016 rf_wdata  output  32  registered write data.

Function
REQ-017 Single register-file write port; one write per cycle; rf_* one cycle after grant.
REQ-018 MDU push when mdu_valid && mdu_ready; mdu_ready = FIFO not full, independent of same-cycle pop.
REQ-019 Grant rule: pipe_we=1 and no forced drain -> pipeline granted; FIFO untouched.
REQ-020 Grant rule: pipe_we=0 and FIFO non-empty -> FIFO head granted and popped.
REQ-021 Forced drain: starve counter == STARVE_LIMIT and FIFO non-empty -> FIFO head granted, pipe_stall=1 if pipe_we=1; the stalled pipeline request is re-presented next cycle.
REQ-022 Starve counter: increments on pipeline grant while FIFO non-empty; clears on any FIFO pop or when FIFO empty; saturates at STARVE_LIMIT.
REQ-023 pipe_stall is 0 in every cycle except a forced drain.
REQ-024 Grant with destination 0 -> no write: rf_we=0 next cycle, FIFO still popped, counter rules unchanged.
REQ-025 No grant -> rf_we=0; rf_waddr/rf_wdata hold previous values.
REQ-026 FIFO order strictly first-in first-out; pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
REQ-027 Push into empty FIFO is not grantable in the same cycle (head visible next cycle).
REQ-028 mdu_pending reflects registered FIFO count only.

Reset
REQ-029 rst=1 asynchronously: FIFO empty, pointers 0, starve counter 0, rf_we=0, rf_waddr=0, rf_wdata=0.
REQ-030 Reset mid-drain discards FIFO contents; after release mdu_ready=1, mdu_pending=0, pipe_stall=0.

Configuration
REQ-031 Macro WB_STARVE_GUARD_EN defined: REQ-021/022 active.
REQ-032 Macro undefined: no counter, pipe_stall tied 0, FIFO drains only in cycles with pipe_we=0.

Structure
REQ-033 Shared package holds register-index width (5), data width (32), and a writeback-request struct {we, reg, data}.
REQ-034 One sub-module wb_req_fifo (parameterised FIFO, push/pop/head/count); arbitration and counter in the top.

Verification
REQ-035 Idle FIFO, pipe_we=1 reg=8 data=0x12345678 -> next cycle rf_we=1, rf_waddr=8, rf_wdata=0x12345678, pipe_stall=0.
REQ-036 pipe_we=0, push mdu reg=3 data=0xA then reg=4 data=0xB -> rf writes reg 3 then reg 4, in order; mdu_pending falls after second pop.
REQ-037 FIFO holds 2, mdu_valid=1 -> mdu_ready=0, no push, no data loss.
REQ-038 Guard on, FIFO holds 1, pipe_we=1 continuously -> pipeline granted 4 cycles, 5th cycle pipe_stall=1 and FIFO head written, 6th cycle pipeline write resumes.
REQ-039 pipe_we=1 reg=0 -> rf_we=0 next cycle; MDU entry reg=0 popped with rf_we=0.
REQ-040 rst asserted asynchronously with FIFO holding 2 -> rf_we=0, mdu_pending=0, mdu_ready=1 immediately, no write after release.
